// File: rtl/prism_counter_bank.sv
// prism_counter_bank: bank of NUM_CH preloadable down-counters driven by FSM strobes,
// with zero flags, sticky terminal-count events and a maskable interrupt on a 6-bit register bus.
module prism_counter_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        address,
    input  logic [31:0]       data_in,
    input  logic [1:0]        data_write_n,
    output logic [31:0]       data_out,
    input  logic              fsm_run,
    input  logic [NUM_CH-1:0] dec_req,
    input  logic [NUM_CH-1:0] load_req,
    output logic [NUM_CH-1:0] zero,
    output logic              irq
);
    logic [CNT_W-1:0]  preload [NUM_CH];
    logic [CNT_W-1:0]  count   [NUM_CH];
    logic [NUM_CH-1:0] auto_reload, irq_en, status, ev, wr_pre, wr_cnt, w1c;
    logic              cnt_en, wr, act;
    logic              unused_data;
    assign wr          = data_write_n == 2'b10;
    assign act         = fsm_run & cnt_en;
    assign irq         = |(status & irq_en);
    assign w1c         = (wr && address == 6'h04) ? data_in[NUM_CH-1:0] : {NUM_CH{1'b0}};
    assign unused_data = ^data_in;
    always_comb begin
        data_out = '0;
        wr_pre   = '0;
        wr_cnt   = '0;
        zero     = '0;
        ev       = '0;
        if (address == 6'h00) begin
            data_out[NUM_CH-1:0]  = auto_reload;
            data_out[8 +: NUM_CH] = irq_en;
            data_out[16]          = cnt_en;
        end
        if (address == 6'h04) data_out[NUM_CH-1:0] = status;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_pre[c] = wr && address == 6'(16 + 8 * c);
            wr_cnt[c] = wr && address == 6'(20 + 8 * c);
            zero[c]   = count[c] == '0;
            // only a plain decrement from 1 is a terminal count; writes and reloads pre-empt it
            ev[c]     = act && dec_req[c] && !load_req[c] && !wr_cnt[c] && count[c] == CNT_W'(1);
            if (address == 6'(16 + 8 * c)) data_out = 32'(preload[c]);
            if (address == 6'(20 + 8 * c)) data_out = 32'(count[c]);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_reload <= '0;
            irq_en      <= '0;
            cnt_en      <= 1'b0;
            status      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                preload[c] <= '0;
                count[c]   <= '0;
            end
        end else begin
            if (wr && address == 6'h00) begin
                auto_reload <= data_in[NUM_CH-1:0];
                irq_en      <= data_in[8 +: NUM_CH];
                cnt_en      <= data_in[16];
            end
            status <= (status & ~w1c) | ev;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_pre[c]) preload[c] <= data_in[CNT_W-1:0];
                if (wr_cnt[c]) count[c] <= data_in[CNT_W-1:0];
                else if (act && load_req[c]) count[c] <= preload[c];
                else if (act && dec_req[c])
                    count[c] <= zero[c] ? (auto_reload[c] ? preload[c] : count[c]) : count[c] - CNT_W'(1);
            end
        end
    end
endmodule
